cic_integrator_decim: RTL
=========================

CIC_INTEGRATOR_DECIM -- requirements
Module: cic_integrator_decim

Interface
REQ-001 Parameter N, default 3, number of cascaded integrator stages (1..6).
REQ-002 Parameter R, default 8, decimation ratio (2..256).
REQ-003 Parameter IW, default 12, input sample width.
REQ-004 Parameter GW, default 21, internal/output width; GW >= IW + N*ceil(log2(R)).
REQ-005 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 clr  input  1  synchronous flush of all integrators, pipeline and decimation counter.
REQ-008 in_valid  input  1  x carries a new sample this cycle.
REQ-009 x  input  IW signed  input sample.
REQ-010 y  output  GW signed  decimated integrator output, feeding the comb stage.
REQ-011 out_valid  output  1  one-cycle strobe; y is valid this cycle.

Function
REQ-012 x SHALL be sign-extended to GW bits before stage 1.
REQ-013 Stage k (1..N) SHALL be a registered accumulator: acc_k <= acc_k + in_k, where in_1 = sign-extended x and in_k = acc_(k-1) for k > 1.
REQ-014 Stage k SHALL update only in the cycle its input valid is high; a valid bit SHALL advance one stage per cycle with the data.
REQ-015 Arithmetic SHALL be two's complement modulo 2^GW: wrap silently, no saturation, no overflow flag.
REQ-016 A sample accepted with in_valid at edge t SHALL reach acc_N at edge t+N-1.
REQ-017 A decimation counter, range 0..R-1, SHALL increment on each valid emerging from stage N.
REQ-018 When the counter is R-1 and stage N emits a valid, the counter SHALL return to 0, y SHALL load acc_N's new value, and out_valid SHALL be high for exactly the following cycle.
REQ-019 Output latency SHALL be N+1 cycles from the accepting in_valid edge to out_valid high.
REQ-020 The first out_valid after reset or clr SHALL correspond to the R-th accepted sample.
REQ-021 y SHALL hold its value between strobes.
REQ-022 Gaps in in_valid SHALL stall the cascade without altering state; output values SHALL be independent of gap pattern.
REQ-023 With in_valid high every cycle, out_valid SHALL occur exactly every R cycles.
REQ-024 clr high SHALL zero all accumulators, valid pipeline, counter, y and out_valid at that edge.
REQ-025 If clr and in_valid are high in the same cycle, clr SHALL take priority and the sample SHALL be dropped.
REQ-026 Samples in flight at clr SHALL be discarded; no out_valid from them.

Reset
REQ-027 rst_n low SHALL immediately and asynchronously clear all accumulators, valid pipeline, counter, y (0) and out_valid (0).
REQ-028 Reset asserted mid-operation SHALL discard all in-flight samples; after release, behaviour SHALL match a fresh start (REQ-020).
REQ-029 The first sample SHALL be accepted on the first rising edge at which rst_n is high.

Verification
REQ-030 Impulse (defaults): one sample x=1, then x=0 with in_valid held high -> out_valid at samples 7, 15, 23 with y = 36, 136, 300; latency 4 cycles.
REQ-031 Gapped input: same impulse with in_valid high every other cycle -> identical y sequence; out_valid spacing 16 cycles.
REQ-032 Wrap: x=+2047 held continuously -> y equals bit-exact modulo-2^21 reference model through multiple wraps; repeat with x=-2048.
REQ-033 clr mid-stream: clr together with in_valid after 5 samples -> that sample dropped, no out_valid for 8 further samples, then y matches fresh-start model.
REQ-034 Async reset: rst_n pulsed low between clock edges mid-stream -> y=0 and out_valid=0 immediately; post-release output matches fresh start.
REQ-035 Parameter sweep N=1, R=2, GW=13: ramp x=0,1,2,... -> y = running sum at every 2nd sample (1, 6, 15, ...).

Source files
------------

// File: rtl/cic_integrator_decim.sv
// Integrator half of a CIC decimator: N cascaded wrapping accumulators, each gated by a
// valid bit that travels with the data, followed by a 1-in-R output decimator.
module cic_integrator_decim #(
  parameter int unsigned N  = 3,
  parameter int unsigned R  = 8,
  parameter int unsigned IW = 12,
  parameter int unsigned GW = 21
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic signed [IW-1:0] x,
  output logic signed [GW-1:0] y,
  output logic                 out_valid
);

  localparam int unsigned CW = (R > 1) ? $clog2(R) : 1;
  localparam logic [CW-1:0] CntLast = CW'(R - 1);

  logic signed [GW-1:0] acc_q [N];
  logic signed [GW-1:0] acc_d [N];
  logic [N-1:0]         vld_q, vld_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [GW-1:0] y_q, y_d;
  logic                 ov_q, ov_d;
  logic signed [GW-1:0] x_ext;

  assign x_ext = {{(GW - IW){x[IW-1]}}, x};

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    y_d   = y_q;
    ov_d  = 1'b0;

    // Each stage only moves when its own input is valid, so input gaps freeze the cascade.
    vld_d[0] = in_valid;
    if (in_valid) begin
      acc_d[0] = acc_q[0] + x_ext;
    end
    for (int unsigned k = 1; k < N; k++) begin
      vld_d[k] = vld_q[k-1];
      if (vld_q[k-1]) begin
        acc_d[k] = acc_q[k] + acc_q[k-1];
      end
    end

    if (vld_q[N-1]) begin
      if (cnt_q == CntLast) begin
        cnt_d = '0;
        y_d   = acc_q[N-1];
        ov_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Flush wins over a coincident input sample, which is dropped.
    if (clr) begin
      for (int unsigned k = 0; k < N; k++) begin
        acc_d[k] = '0;
      end
      vld_d = '0;
      cnt_d = '0;
      y_d   = '0;
      ov_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N; k++) begin
        acc_q[k] <= '0;
      end
      vld_q <= '0;
      cnt_q <= '0;
      y_q   <= '0;
      ov_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      y_q   <= y_d;
      ov_q  <= ov_d;
    end
  end

  assign y         = y_q;
  assign out_valid = ov_q;

endmodule
